// File: rtl/cs_pkg.sv
// Shared op codes, FSM states and data-memory stack map for the call stack sequencer.
package cs_pkg;

    localparam logic [15:0] DMEM_STACK_BASE  = 16'h00BF;
    localparam logic [15:0] DMEM_STACK_LIMIT = 16'h0040;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } cs_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_DONE  = 2'b11
    } cs_state_e;

    // POP and RET share the low op bit, so reads are identified from it alone.
    function automatic logic op_is_read(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational whole-command bounds check against the current SP, evaluated at acceptance.
module stack_bounds_check
    import cs_pkg::*;
#(
    parameter int                  SP_WIDTH    = 16,
    parameter int                  NBYTES      = 2,
    parameter logic [SP_WIDTH-1:0] STACK_BASE  = SP_WIDTH'(DMEM_STACK_BASE),
    parameter logic [SP_WIDTH-1:0] STACK_LIMIT = SP_WIDTH'(DMEM_STACK_LIMIT)
) (
    input  logic [1:0]          op,
    input  logic [SP_WIDTH-1:0] sp,
    output logic                fault
);

    localparam int EW = SP_WIDTH + 1;

    logic [EW-1:0] sp_x;
    logic [EW-1:0] base_x;
    logic [EW-1:0] limit_x;

    // One extra bit so sp+N and limit+N never wrap.
    assign sp_x    = {1'b0, sp};
    assign base_x  = {1'b0, STACK_BASE};
    assign limit_x = {1'b0, STACK_LIMIT};

    always_comb begin
        fault = 1'b0;
        case (cs_op_e'(op))
            OP_PUSH: fault = (sp_x < limit_x);
            OP_CALL: fault = (sp_x < limit_x) || (sp_x < limit_x + EW'(NBYTES - 1));
            OP_POP:  fault = (sp_x + EW'(1) > base_x);
            OP_RET:  fault = (sp_x + EW'(NBYTES) > base_x);
            default: fault = 1'b0;
        endcase
    end

endmodule

// File: rtl/call_stack_sequencer.sv
// Byte-serial PUSH/POP/CALL/RET engine on a descending stack; 1+N cycles accept-to-done at zero wait.
// One command in flight: cmd_ready only in IDLE, memory stalls simply extend mem_req with outputs held.
module call_stack_sequencer
    import cs_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 8,
    parameter int                  PC_WIDTH    = 10,
    parameter int                  SP_WIDTH    = 16,
    parameter logic [SP_WIDTH-1:0] STACK_BASE  = SP_WIDTH'(DMEM_STACK_BASE),
    parameter logic [SP_WIDTH-1:0] STACK_LIMIT = SP_WIDTH'(DMEM_STACK_LIMIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [PC_WIDTH-1:0]   cmd_pc,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  sp_load,
    input  logic [SP_WIDTH-1:0]   sp_load_value,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [SP_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  done,
    output logic                  error,
    output logic [PC_WIDTH-1:0]   ret_pc,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [SP_WIDTH-1:0]   sp,
    output logic                  ovf_flag,
    output logic                  unf_flag
);

    localparam int NBYTES = (PC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int SHW    = NBYTES * DATA_WIDTH;
    localparam int CW     = $clog2(NBYTES + 1);

    cs_state_e             state_q, state_d;
    logic [SP_WIDTH-1:0]   sp_q, sp_d;
    logic [1:0]            op_q, op_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SHW-1:0]        shift_q, shift_d;
    logic                  error_q, error_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [PC_WIDTH-1:0]   ret_pc_q, ret_pc_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

    logic accept;
    logic fault;
    logic last_byte;

    stack_bounds_check #(
        .SP_WIDTH    (SP_WIDTH),
        .NBYTES      (NBYTES),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bounds (
        .op    (cmd_op),
        .sp    (sp_q),
        .fault (fault)
    );

    assign accept    = cmd_valid && cmd_ready;
    assign last_byte = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sp_q       <= STACK_BASE;
            op_q       <= 2'b00;
            cnt_q      <= '0;
            shift_q    <= '0;
            error_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            ret_pc_q   <= '0;
            pop_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            error_q    <= error_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            ret_pc_q   <= ret_pc_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fault)                   state_d = ST_DONE;
                    else if (op_is_read(cmd_op)) state_d = ST_READ;
                    else                         state_d = ST_WRITE;
                end
            end
            ST_WRITE,
            ST_READ: begin
                if (mem_ack && last_byte) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sp_d       = sp_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        error_d    = error_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        ret_pc_d   = ret_pc_q;
        pop_data_d = pop_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sp_load) begin
                    sp_d  = sp_load_value;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                end else if (accept) begin
                    op_d    = cmd_op;
                    error_d = fault;
                    shift_d = (cmd_op == OP_CALL) ? SHW'(cmd_pc) : SHW'(cmd_data);
                    cnt_d   = (cmd_op == OP_CALL || cmd_op == OP_RET) ? CW'(NBYTES) : CW'(1);
                    if (fault) begin
                        if (op_is_read(cmd_op)) unf_d = 1'b1;
                        else                    ovf_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // Post-decrement; CALL shifts the next-higher byte into the low lane.
                if (mem_ack) begin
                    sp_d    = sp_q - SP_WIDTH'(1);
                    shift_d = shift_q >> DATA_WIDTH;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            ST_READ: begin
                // RET reads MSB first, so each byte shifts in from the bottom.
                if (mem_ack) begin
                    sp_d    = sp_q + SP_WIDTH'(1);
                    shift_d = (shift_q << DATA_WIDTH) | SHW'(mem_rdata);
                    cnt_d   = cnt_q - CW'(1);
                    if (last_byte) begin
                        if (op_q == OP_RET) ret_pc_d   = shift_d[PC_WIDTH-1:0];
                        else                pop_data_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !sp_load;
        mem_req   = (state_q == ST_WRITE) || (state_q == ST_READ);
        mem_we    = (state_q == ST_WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_WRITE) begin
            mem_addr  = sp_q;
            mem_wdata = shift_q[DATA_WIDTH-1:0];
        end else if (state_q == ST_READ) begin
            mem_addr = sp_q + SP_WIDTH'(1);
        end
        done  = (state_q == ST_DONE);
        error = (state_q == ST_DONE) && error_q;
    end

    assign sp       = sp_q;
    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;
    assign ret_pc   = ret_pc_q;
    assign pop_data = pop_data_q;

endmodule

// File: tb/tb_call_stack_sequencer.sv
// Randomised bench for call_stack_sequencer with a command-level stack model and a latency-programmable memory.
module tb_call_stack_sequencer;
    import cs_pkg::*;

    localparam int NB    = 2;
    localparam int BASE  = 'hBF;
    localparam int LIMIT = 'h40;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  dat;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [9:0]  cmd_pc = '0;
    logic [7:0]  cmd_data = '0;
    logic        sp_load = 1'b0;
    logic [15:0] sp_load_value = '0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        error;
    logic [9:0]  ret_pc;
    logic [7:0]  pop_data;
    logic [15:0] sp;
    logic        ovf_flag;
    logic        unf_flag;

    call_stack_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_pc        (cmd_pc),
        .cmd_data      (cmd_data),
        .sp_load       (sp_load),
        .sp_load_value (sp_load_value),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .done          (done),
        .error         (error),
        .ret_pc        (ret_pc),
        .pop_data      (pop_data),
        .sp            (sp),
        .ovf_flag      (ovf_flag),
        .unf_flag      (unf_flag)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          m_sp = BASE;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    logic [9:0]  m_ret = '0;
    logic [7:0]  m_pop = '0;
    logic [7:0]  ref_mem [256];
    logic [7:0]  dut_mem [256];
    acc_t        log_q [$];
    int          cur_delay = 0;
    bit          idle_chk = 0;
    bit          busy = 0;
    int          wl = 0;
    acc_t        held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder plus per-cycle output checks, all at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            busy    = 0;
            mem_ack = 1'b0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    wl   = cur_delay;
                    held = '{mem_addr, mem_we, mem_wdata};
                end else begin
                    chk("mem_hold", 32'({mem_addr, mem_we, mem_wdata}), 32'(held));
                end
                if (wl == 0) begin
                    mem_ack = 1'b1;
                    busy    = 0;
                    if (mem_we) dut_mem[mem_addr[7:0]] = mem_wdata;
                    else        mem_rdata = dut_mem[mem_addr[7:0]];
                    log_q.push_back('{mem_addr, mem_we, mem_we ? mem_wdata : mem_rdata});
                end else begin
                    wl--;
                end
            end
            chk("done_excl_req", 32'(done & mem_req), 0);
            chk("error_only_with_done", 32'(error & ~done), 0);
            if (idle_chk) begin
                chk("idle_sp", 32'(sp), 32'(16'(m_sp)));
                chk("idle_flags", 32'({ovf_flag, unf_flag}), 32'({m_ovf, m_unf}));
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input bit with_cmd);
        @(negedge clk);
        sp_load = 1'b1; sp_load_value = v;
        cmd_valid = with_cmd; cmd_op = OP_PUSH; cmd_data = 8'hEE;
        #1 chk("load_ready_low", 32'(cmd_ready), 0);
        @(posedge clk);
        #1 sp_load = 1'b0; cmd_valid = 1'b0;
        m_sp = int'(v); m_ovf = 0; m_unf = 0;
        @(negedge clk);
        chk("load_sp", 32'(sp), 32'(v));
        chk("load_no_req", 32'(mem_req), 0);
        chk("load_flags", 32'({ovf_flag, unf_flag}), 0);
        @(negedge clk);
        chk("load_no_done", 32'(done), 0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [9:0] pc, input logic [7:0] dat,
                          input int dly, input bit mid_load);
        int s, e_sp, v, cyc, nb, lat;
        bit flt, got, e_ovf, e_unf;
        logic [7:0] b;
        logic [9:0] e_ret;
        logic [7:0] e_pop;
        acc_t exp_q [$];
        s = m_sp; e_sp = s; e_ovf = m_ovf; e_unf = m_unf; e_ret = m_ret; e_pop = m_pop;
        nb = (op == OP_CALL || op == OP_RET) ? NB : 1;
        case (op)
            OP_PUSH: flt = (s < LIMIT);
            OP_CALL: flt = (s - (NB - 1) < LIMIT) || (s < LIMIT);
            OP_POP:  flt = (s + 1 > BASE);
            default: flt = (s + NB > BASE);
        endcase
        if (flt) begin
            if (op == OP_PUSH || op == OP_CALL) e_ovf = 1; else e_unf = 1;
        end else if (op == OP_PUSH) begin
            exp_q.push_back('{16'(s), 1'b1, dat});
            ref_mem[s & 255] = dat;
            e_sp = s - 1;
        end else if (op == OP_CALL) begin
            v = int'(pc);
            for (int i = 0; i < NB; i++) begin
                b = 8'(v >> (8 * i));
                exp_q.push_back('{16'(s - i), 1'b1, b});
                ref_mem[(s - i) & 255] = b;
            end
            e_sp = s - NB;
        end else if (op == OP_POP) begin
            b = ref_mem[(s + 1) & 255];
            exp_q.push_back('{16'(s + 1), 1'b0, b});
            e_pop = b; e_sp = s + 1;
        end else begin
            v = 0;
            for (int i = 0; i < NB; i++) begin
                b = ref_mem[(s + 1 + i) & 255];
                exp_q.push_back('{16'(s + 1 + i), 1'b0, b});
                v = (v << 8) | int'(b);
            end
            e_ret = 10'(v); e_sp = s + NB;
        end
        lat = flt ? 1 : 1 + nb * (dly + 1);

        @(negedge clk);
        log_q.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_pc = pc; cmd_data = dat; cur_delay = dly;
        #1 chk("cmd_ready", 32'(cmd_ready), 1);
        idle_chk = 0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_pc = 10'($urandom); cmd_data = 8'($urandom);
        cyc = 0; got = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mid_load && cyc == 1) begin
                sp_load = 1'b1; sp_load_value = 16'h0099;
            end else begin
                sp_load = 1'b0;
            end
            if (done) got = 1;
        end
        sp_load = 1'b0;
        m_sp = e_sp; m_ovf = e_ovf; m_unf = e_unf; m_ret = e_ret; m_pop = e_pop;
        chk("done_seen", 32'(got), 1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("error", 32'(error), 32'(flt));
        chk("sp", 32'(sp), 32'(16'(e_sp)));
        chk("flags", 32'({ovf_flag, unf_flag}), 32'({e_ovf, e_unf}));
        chk("ret_pc", 32'(ret_pc), 32'(e_ret));
        chk("pop_data", 32'(pop_data), 32'(e_pop));
        chk("n_access", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk("access", 32'(log_q[i]), 32'(exp_q[i]));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("ready_after", 32'(cmd_ready), 1);
        idle_chk = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done;
        logic [7:0] rv;
        int r;
        for (int i = 0; i < 256; i++) begin
            rv = 8'($urandom);
            ref_mem[i] = rv;
            dut_mem[i] = rv;
        end

        repeat (2) @(negedge clk);
        chk("rst_sp", 32'(sp), 32'h00BF);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_out", 32'({mem_we, mem_addr, mem_wdata}), 0);
        chk("rst_done_err", 32'({done, error}), 0);
        chk("rst_ret_pop", 32'({ret_pc, pop_data}), 0);
        chk("rst_flags", 32'({ovf_flag, unf_flag}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);
        idle_chk = 1;

        // CALL then RET round trip at the top of the stack.
        do_cmd(OP_CALL, 10'h2A5, 8'h00, 0, 0);
        chk("lit_call_sp", 32'(sp), 32'h00BD);
        chk("lit_call_b0", 32'(log_q[0]), 32'({16'h00BF, 1'b1, 8'hA5}));
        chk("lit_call_b1", 32'(log_q[1]), 32'({16'h00BE, 1'b1, 8'h02}));
        do_cmd(OP_RET, 10'h000, 8'h00, 0, 0);
        chk("lit_ret_pc", 32'(ret_pc), 32'h2A5);
        chk("lit_ret_sp", 32'(sp), 32'h00BF);
        chk("lit_ret_b0", 32'(log_q[0]), 32'({16'h00BE, 1'b0, 8'h02}));

        // Underflow, then cleared by a load.
        do_cmd(OP_POP, 10'h000, 8'h00, 0, 0);
        chk("lit_pop_unf", 32'({error_seen_dummy(), unf_flag}), 32'({1'b0, 1'b1}));
        chk("lit_pop_noacc", 32'(log_q.size()), 0);
        do_load(16'h0080, 0);
        chk("lit_load_unf", 32'(unf_flag), 0);

        // Bottom of the stack: last legal push, overflow, then a CALL that just fits.
        do_load(16'h0040, 0);
        do_cmd(OP_PUSH, 10'h000, 8'h5A, 0, 0);
        chk("lit_push_sp", 32'(sp), 32'h003F);
        do_cmd(OP_PUSH, 10'h000, 8'h11, 0, 0);
        chk("lit_push_ovf", 32'(ovf_flag), 1);
        do_load(16'h0041, 0);
        do_cmd(OP_CALL, 10'h3C7, 8'h00, 1, 0);
        chk("lit_call_lo_n", 32'(log_q.size()), 2);
        do_load(16'h0040, 0);
        do_cmd(OP_CALL, 10'h123, 8'h00, 0, 0);

        // Slow memory with an sp_load attempt while busy.
        do_load(16'h0090, 0);
        do_cmd(OP_PUSH, 10'h000, 8'h33, 3, 1);
        chk("lit_slow_sp", 32'(sp), 32'h008F);

        // Reset during the second byte of a CALL.
        do_load(16'h00BF, 0);
        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_CALL; cmd_pc = 10'h155; cur_delay = 2;
        idle_chk = 0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_first_byte", 32'(log_q.size()), 1);
        chk("rst_mid_req_before", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1 chk("rst_mid_req_drop", 32'(mem_req), 0);
        chk("rst_mid_sp", 32'(sp), 32'h00BF);
        ref_mem[BASE] = 8'h55;
        m_sp = BASE; m_ovf = 0; m_unf = 0; m_ret = '0; m_pop = '0;
        @(negedge clk);
        #1 reset = 1'b0;
        got_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        chk("rst_mid_no_done", 32'(got_done), 0);
        chk("rst_mid_ready", 32'(cmd_ready), 1);
        chk("rst_mid_ret_pop", 32'({ret_pc, pop_data}), 0);
        idle_chk = 1;

        // Load wins over a simultaneous command.
        do_load(16'h0070, 1);
        chk("lit_loadwin_sp", 32'(sp), 32'h0070);

        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                do_load(16'($urandom_range('h38, 'hC4)), $urandom_range(0, 1) == 1);
            else
                do_cmd(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
                       8'($urandom), int'($urandom_range(0, 2)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // error is only valid alongside done, which has already fallen when this is sampled.
    function automatic logic error_seen_dummy();
        return error;
    endfunction

endmodule
